div255_seq: RTL

Sequencer for the shared 16-bit-sliced divide-by-255 datapath (`Divby255`-style: `x`, `flg1`..`flg4`, `y`). It accepts a 32-bit dividend on a valid/ready port and drives the datapath's four phase flags in order: load dividend MSB, load dividend LSB, read quotient MSB, read quotient LSB. It collects the two 16-bit quotient halves and presents the 32-bit quotient on a valid/ready output port. It sits between the requesting logic and the datapath instance; the datapath itself is outside this block.

---
 rtl/div255_pkg.sv | 16 +
 rtl/div255_seq_if.sv | 31 +++
 rtl/div255_seq_phase_timer.sv | 27 ++
 rtl/div255_seq.sv | 105 ++++++++++
 4 files changed

// File: rtl/div255_pkg.sv
// Shared types and constants for the divide-by-255 sequencer and its benches.
package div255_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LD_HI,
    LD_LO,
    RD_HI,
    RD_LO,
    DONE
  } seq_state_t;

  localparam logic [31:0] DIVISOR = 32'd255;
  localparam logic [31:0] QMAX    = 32'h01010101;

endpackage

// File: rtl/div255_seq_if.sv
// Request/response handshake plus datapath bus between a requester and div255_seq.
interface div255_seq_if;

  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_dividend;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_quotient;
  logic        busy;
  logic [15:0] dp_x;
  logic        dp_flg1;
  logic        dp_flg2;
  logic        dp_flg3;
  logic        dp_flg4;
  logic [15:0] dp_y;

  // master is the requester side, which also hosts the external datapath
  modport master (
    output in_valid, in_dividend, out_ready, dp_y,
    input  in_ready, out_valid, out_quotient, busy,
    input  dp_x, dp_flg1, dp_flg2, dp_flg3, dp_flg4
  );

  modport slave (
    input  in_valid, in_dividend, out_ready, dp_y,
    output in_ready, out_valid, out_quotient, busy,
    output dp_x, dp_flg1, dp_flg2, dp_flg3, dp_flg4
  );

endinterface

// File: rtl/div255_seq_phase_timer.sv
// Phase-length counter: reloads on load and flags the final cycle of each phase.
module phase_timer #(
  parameter int unsigned SETTLE = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  output logic last
);

  localparam logic [3:0] RELOAD = 4'(SETTLE - 1);

  logic [3:0] count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= 4'd0;
    end else if (load) begin
      count <= RELOAD;
    end else if (count != 4'd0) begin
      count <= count - 4'd1;
    end
  end

  assign last = (count == 4'd0);

endmodule

// File: rtl/div255_seq.sv
// Sequencer driving the four phase flags of the shared divide-by-255 datapath.
module div255_seq
  import div255_pkg::*;
#(
  parameter int unsigned SETTLE = 2
) (
  input  logic         clk,
  input  logic         rst,
  div255_seq_if.slave  bus
);

  seq_state_t  state;
  seq_state_t  next_state;
  logic        load;
  logic        last;
  logic [31:0] dividend;
  logic [15:0] q_hi;
  logic [15:0] q_hi_out;
  logic [15:0] q_lo;
  logic [15:0] dp_x_next;
  logic [15:0] dp_x_reg;
  logic        flg1, flg2, flg3, flg4;
  logic        in_ready_reg, out_valid_reg, busy_reg;

  phase_timer #(.SETTLE(SETTLE)) u_timer (
    .clk  (clk),
    .rst  (rst),
    .load (load),
    .last (last)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= next_state;
  end

  // in_ready is only high in IDLE, so in_valid there is the accept
  always_comb begin
    next_state = state;
    load       = 1'b0;
    case (state)
      IDLE:  if (bus.in_valid) begin next_state = LD_HI; load = 1'b1; end
      LD_HI: if (last)         begin next_state = LD_LO; load = 1'b1; end
      LD_LO: if (last)         begin next_state = RD_HI; load = 1'b1; end
      RD_HI: if (last)         begin next_state = RD_LO; load = 1'b1; end
      RD_LO: if (last)         next_state = DONE;
      DONE:  if (bus.out_ready) next_state = IDLE;
      default:                 next_state = IDLE;
    endcase
  end

  // On the accept edge the dividend register is not yet loaded, so bypass it
  always_comb begin
    dp_x_next = 16'h0000;
    case (next_state)
      LD_HI:   dp_x_next = (state == IDLE) ? bus.in_dividend[31:16] : dividend[31:16];
      LD_LO:   dp_x_next = dividend[15:0];
      default: dp_x_next = 16'h0000;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dividend      <= 32'd0;
      q_hi          <= 16'h0000;
      q_hi_out      <= 16'h0000;
      q_lo          <= 16'h0000;
      dp_x_reg      <= 16'h0000;
      flg1          <= 1'b0;
      flg2          <= 1'b0;
      flg3          <= 1'b0;
      flg4          <= 1'b0;
      in_ready_reg  <= 1'b1;
      out_valid_reg <= 1'b0;
      busy_reg      <= 1'b0;
    end else begin
      if (state == IDLE && bus.in_valid) dividend <= bus.in_dividend;
      if (state == RD_HI && last) q_hi <= bus.dp_y;
      // Both halves of the visible quotient update together, at the final capture
      if (state == RD_LO && last) begin
        q_hi_out <= q_hi;
        q_lo     <= bus.dp_y;
      end
      dp_x_reg      <= dp_x_next;
      flg1          <= (next_state == LD_HI);
      flg2          <= (next_state == LD_LO);
      flg3          <= (next_state == RD_HI);
      flg4          <= (next_state == RD_LO);
      in_ready_reg  <= (next_state == IDLE);
      out_valid_reg <= (next_state == DONE);
      busy_reg      <= (next_state != IDLE);
    end
  end

  assign bus.in_ready     = in_ready_reg;
  assign bus.out_valid    = out_valid_reg;
  assign bus.busy         = busy_reg;
  assign bus.out_quotient = {q_hi_out, q_lo};
  assign bus.dp_x         = dp_x_reg;
  assign bus.dp_flg1      = flg1;
  assign bus.dp_flg2      = flg2;
  assign bus.dp_flg3      = flg3;
  assign bus.dp_flg4      = flg4;

endmodule
